// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU-op encodings and the ID/EX control bundle.
package decode_pkg;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;

   typedef enum logic [1:0] {
      AluAdd   = 2'b00,
      AluSub   = 2'b01,
      AluFunct = 2'b10,
      AluLogic = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      logic    reg_dst;
      alu_op_e alu_op;
   } ctrl_t;

   // Main control decoder; unknown opcodes and branches yield an all-zero bundle.
   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OpRtype: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = AluFunct;
         end
         OpLw: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         OpSw: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         OpAddi: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = AluAdd;
         end
         OpAndi, OpOri: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = AluLogic;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/register_file.sv
// 2-read / 1-write register file with hard-wired r0 and write-to-read bypass.
module register_file #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned NREG   = 32,
   localparam int unsigned RegAw  = $clog2(NREG)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [RegAw-1:0]  raddr1_i,
   input  logic [RegAw-1:0]  raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              we_i,
   input  logic [RegAw-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];
   logic              wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   // Next-state of the array: only the addressed, nonzero register changes.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   // Register array storage, cleared by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Reads: r0 is zero; a same-cycle write to the read address is forwarded.
   always_comb begin
      rdata1_o = mem_q[raddr1_i];
      rdata2_o = mem_q[raddr2_i];
      if (raddr1_i == '0) begin
         rdata1_o = '0;
      end else if (wr_en && (waddr_i == raddr1_i)) begin
         rdata1_o = wdata_i;
      end
      if (raddr2_i == '0) begin
         rdata2_o = '0;
      end else if (wr_en && (waddr_i == raddr2_i)) begin
         rdata2_o = wdata_i;
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, register read, early branch resolution, hazard detection, ID/EX register.
module instruction_decode
   import decode_pkg::*;
#(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instruccion,
   input  logic [ADDR_W-1:0] pc,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic              exmem_mem_read,
   input  logic [4:0]        exmem_write_reg,
   output logic [ADDR_W-1:0] pc_salto,
   output logic              PCSrc,
   output logic              stall,
   output logic              flush_if_id,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_alu_src,
   output logic              ex_reg_dst,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_dato1,
   output logic [DATA_W-1:0] ex_dato2,
   output logic [DATA_W-1:0] ex_inmediato,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd
);

   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic [15:0]       imm16;
   ctrl_t             ctrl_dec;
   logic [DATA_W-1:0] imm_ext, rs_val, rt_val;
   logic              is_beq, is_bne, is_branch, zero_ext, rt_used;
   logic [4:0]        ex_dest;
   logic              load_use, branch_haz, taken;

   ctrl_t             ex_ctrl_q, ex_ctrl_d;
   logic [DATA_W-1:0] ex_dato1_q, ex_dato1_d;
   logic [DATA_W-1:0] ex_dato2_q, ex_dato2_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic [4:0]        ex_rs_q, ex_rs_d;
   logic [4:0]        ex_rt_q, ex_rt_d;
   logic [4:0]        ex_rd_q, ex_rd_d;

   assign opcode = instruccion[31:26];
   assign rs     = instruccion[25:21];
   assign rt     = instruccion[20:16];
   assign rd     = instruccion[15:11];
   assign imm16  = instruccion[15:0];

   register_file #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_register_file (
      .clock    (clock),
      .reset    (reset),
      .raddr1_i (rs),
      .raddr2_i (rt),
      .rdata1_o (rs_val),
      .rdata2_o (rt_val),
      .we_i     (wb_reg_write),
      .waddr_i  (wb_write_reg),
      .wdata_i  (wb_write_data)
   );

   // Control decode and immediate extension.
   always_comb begin
      ctrl_dec  = decode_ctrl(opcode);
      is_beq    = (opcode == OpBeq);
      is_bne    = (opcode == OpBne);
      is_branch = is_beq || is_bne;
      zero_ext  = (opcode == OpAndi) || (opcode == OpOri);
      rt_used   = (opcode == OpRtype) || (opcode == OpSw) || is_branch;
      imm_ext   = zero_ext ? {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};
   end

   // Hazard detection and branch resolution; stall overrides any branch outcome.
   always_comb begin
      ex_dest    = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;
      load_use   = ex_ctrl_q.mem_read && (ex_rt_q != '0) &&
                   ((ex_rt_q == rs) || (rt_used && (ex_rt_q == rt)));
      branch_haz = is_branch &&
                   ((ex_ctrl_q.reg_write && (ex_dest != '0) &&
                     ((ex_dest == rs) || (ex_dest == rt))) ||
                    (exmem_mem_read && (exmem_write_reg != '0) &&
                     ((exmem_write_reg == rs) || (exmem_write_reg == rt))));
      stall       = load_use || branch_haz;
      taken       = !stall && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));
      PCSrc       = taken;
      flush_if_id = taken;
      // Offset truncated to the PC width so the target wraps modulo 2^ADDR_W.
      pc_salto    = pc + imm_ext[ADDR_W-1:0];
   end

   // ID/EX next state: a stall inserts a bubble by zeroing control only.
   always_comb begin
      ex_ctrl_d  = stall ? '0 : ctrl_dec;
      ex_dato1_d = rs_val;
      ex_dato2_d = rt_val;
      ex_imm_d   = imm_ext;
      ex_rs_d    = rs;
      ex_rt_d    = rt;
      ex_rd_d    = rd;
   end

   // ID/EX pipeline register, loaded every cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_ctrl_q  <= '0;
         ex_dato1_q <= '0;
         ex_dato2_q <= '0;
         ex_imm_q   <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_rd_q    <= '0;
      end else begin
         ex_ctrl_q  <= ex_ctrl_d;
         ex_dato1_q <= ex_dato1_d;
         ex_dato2_q <= ex_dato2_d;
         ex_imm_q   <= ex_imm_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_rd_q    <= ex_rd_d;
      end
   end

   assign ex_reg_write  = ex_ctrl_q.reg_write;
   assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
   assign ex_mem_read   = ex_ctrl_q.mem_read;
   assign ex_mem_write  = ex_ctrl_q.mem_write;
   assign ex_alu_src    = ex_ctrl_q.alu_src;
   assign ex_reg_dst    = ex_ctrl_q.reg_dst;
   assign ex_alu_op     = ex_ctrl_q.alu_op;
   assign ex_dato1      = ex_dato1_q;
   assign ex_dato2      = ex_dato2_q;
   assign ex_inmediato  = ex_imm_q;
   assign ex_rs         = ex_rs_q;
   assign ex_rt         = ex_rt_q;
   assign ex_rd         = ex_rd_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios then randomized traffic.
module tb_instruction_decode;

   logic        clock;
   logic        reset;
   logic [31:0] instruccion;
   logic [10:0] pc;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        exmem_mem_read;
   logic [4:0]  exmem_write_reg;
   logic [10:0] pc_salto;
   logic        PCSrc, stall, flush_if_id;
   logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
   logic [1:0]  ex_alu_op;
   logic [31:0] ex_dato1, ex_dato2, ex_inmediato;
   logic [4:0]  ex_rs, ex_rt, ex_rd;

   instruction_decode dut (
      .clock           (clock),
      .reset           (reset),
      .instruccion     (instruccion),
      .pc              (pc),
      .wb_reg_write    (wb_reg_write),
      .wb_write_reg    (wb_write_reg),
      .wb_write_data   (wb_write_data),
      .exmem_mem_read  (exmem_mem_read),
      .exmem_write_reg (exmem_write_reg),
      .pc_salto        (pc_salto),
      .PCSrc           (PCSrc),
      .stall           (stall),
      .flush_if_id     (flush_if_id),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .ex_mem_read     (ex_mem_read),
      .ex_mem_write    (ex_mem_write),
      .ex_alu_src      (ex_alu_src),
      .ex_reg_dst      (ex_reg_dst),
      .ex_alu_op       (ex_alu_op),
      .ex_dato1        (ex_dato1),
      .ex_dato2        (ex_dato2),
      .ex_inmediato    (ex_inmediato),
      .ex_rs           (ex_rs),
      .ex_rt           (ex_rt),
      .ex_rd           (ex_rd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        rw, m2r, mr, mw, as, rdst;
      logic [1:0]  aop;
      logic [31:0] d1, d2, imm;
      logic [4:0]  rs, rt, rd;
   } ex_t;

   logic [31:0] m_regs [32];
   ex_t         m_ex;
   int          errors = 0;
   int          checks = 0;
   logic        obs_stall, obs_pcsrc;
   logic [10:0] obs_salto;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wb_reg_write && (wb_write_reg == a)) return wb_write_data;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      m_ex = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
   endtask

   task automatic check_ex();
      check("ex_reg_write",  32'(ex_reg_write),  32'(m_ex.rw));
      check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m_ex.m2r));
      check("ex_mem_read",   32'(ex_mem_read),   32'(m_ex.mr));
      check("ex_mem_write",  32'(ex_mem_write),  32'(m_ex.mw));
      check("ex_alu_src",    32'(ex_alu_src),    32'(m_ex.as));
      check("ex_reg_dst",    32'(ex_reg_dst),    32'(m_ex.rdst));
      check("ex_alu_op",     32'(ex_alu_op),     32'(m_ex.aop));
      check("ex_dato1",      ex_dato1,           m_ex.d1);
      check("ex_dato2",      ex_dato2,           m_ex.d2);
      check("ex_inmediato",  ex_inmediato,       m_ex.imm);
      check("ex_rs",         32'(ex_rs),         32'(m_ex.rs));
      check("ex_rt",         32'(ex_rt),         32'(m_ex.rt));
      check("ex_rd",         32'(ex_rd),         32'(m_ex.rd));
   endtask

   // One clock of the reference model: check combinational outputs, clock, check ID/EX.
   task automatic cycle();
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, dest;
      logic [15:0] imm16;
      logic [31:0] a, b;
      logic        zext, br, rt_src, lu, bh, e_stall, e_taken;
      int          simm, target;
      ex_t         nx;
      #1;
      op    = instruccion[31:26];
      rs    = instruccion[25:21];
      rt    = instruccion[20:16];
      rd    = instruccion[15:11];
      imm16 = instruccion[15:0];
      nx    = '0;
      zext  = 1'b0;
      br    = 1'b0;
      case (op)
         6'h00: begin nx.rdst = 1; nx.rw = 1; nx.aop = 2'd2; end
         6'h23: begin nx.as = 1; nx.mr = 1; nx.m2r = 1; nx.rw = 1; end
         6'h2B: begin nx.as = 1; nx.mw = 1; end
         6'h08: begin nx.as = 1; nx.rw = 1; end
         6'h0C, 6'h0D: begin nx.as = 1; nx.rw = 1; nx.aop = 2'd3; zext = 1; end
         6'h04, 6'h05: br = 1;
         default: ;
      endcase
      rt_src = (op == 6'h00) || (op == 6'h2B) || br;
      simm   = zext ? int'({16'h0, imm16}) : int'($signed(imm16));
      a      = m_read(rs);
      b      = m_read(rt);
      lu     = m_ex.mr && (m_ex.rt != 0) && ((m_ex.rt == rs) || (rt_src && (m_ex.rt == rt)));
      dest   = m_ex.rdst ? m_ex.rd : m_ex.rt;
      bh     = br && ((m_ex.rw && (dest != 0) && ((dest == rs) || (dest == rt))) ||
                      (exmem_mem_read && (exmem_write_reg != 0) &&
                       ((exmem_write_reg == rs) || (exmem_write_reg == rt))));
      e_stall = lu || bh;
      e_taken = !e_stall && (((op == 6'h04) && (a == b)) || ((op == 6'h05) && (a != b)));
      target  = (int'(pc) + simm) % 2048;
      if (target < 0) target += 2048;
      obs_stall = stall;
      obs_pcsrc = PCSrc;
      obs_salto = pc_salto;
      check("stall",       32'(stall),       32'(e_stall));
      check("PCSrc",       32'(PCSrc),       32'(e_taken));
      check("flush_if_id", 32'(flush_if_id), 32'(e_taken));
      check("pc_salto",    32'(pc_salto),    target);
      if (e_stall) begin
         nx.rw = 0; nx.m2r = 0; nx.mr = 0; nx.mw = 0; nx.as = 0; nx.rdst = 0; nx.aop = 0;
      end
      nx.d1  = a;
      nx.d2  = b;
      nx.imm = 32'(simm);
      nx.rs  = rs;
      nx.rt  = rt;
      nx.rd  = rd;
      @(posedge clock);
      #1;
      if (wb_reg_write && (wb_write_reg != 0)) m_regs[wb_write_reg] = wb_write_data;
      m_ex = nx;
      check_ex();
   endtask

   task automatic set_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
      instruccion = {op, rs, rt, rd, 11'h0};
   endtask

   task automatic set_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm);
      instruccion = {op, rs, rt, imm};
   endtask

   task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
      instruccion   = 32'hFC00_0000;
      wb_reg_write  = 1'b1;
      wb_write_reg  = r;
      wb_write_data = v;
      cycle();
      wb_reg_write  = 1'b0;
   endtask

   logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h3F};

   initial begin
      reset           = 1'b0;
      instruccion     = 32'hFC00_0000;
      pc              = '0;
      wb_reg_write    = 1'b0;
      wb_write_reg    = '0;
      wb_write_data   = '0;
      exmem_mem_read  = 1'b0;
      exmem_write_reg = '0;
      model_reset();
      @(posedge clock);
      #1;
      check_ex();
      #4 reset = 1'b1;

      // Write-back bypass into a decoding R-type.
      set_r(6'h00, 5'd5, 5'd0, 5'd3);
      wb_reg_write  = 1'b1;
      wb_write_reg  = 5'd5;
      wb_write_data = 32'h0000_1234;
      cycle();
      wb_reg_write  = 1'b0;
      check("wbp_dato1",  ex_dato1, 32'h0000_1234);
      check("wbp_regdst", 32'(ex_reg_dst), 32'h1);
      check("wbp_aluop",  32'(ex_alu_op), 32'h2);

      // Load-use: lw r2,0(r1) then add r4,r2,r3.
      write_reg(5'd1, 32'h40);
      set_i(6'h23, 5'd1, 5'd2, 16'h0);
      cycle();
      set_r(6'h00, 5'd2, 5'd3, 5'd4);
      cycle();
      check("lu_stall",     32'(obs_stall), 32'h1);
      check("lu_bubble_rw", 32'(ex_reg_write), 32'h0);
      cycle();
      check("lu_stall_off", 32'(obs_stall), 32'h0);
      check("lu_issue_rs",  32'(ex_rs), 32'h2);

      // beq taken / not taken.
      write_reg(5'd1, 32'd7);
      write_reg(5'd2, 32'd7);
      pc = 11'h010;
      set_i(6'h04, 5'd1, 5'd2, 16'd4);
      cycle();
      check("beq_pcsrc", 32'(obs_pcsrc), 32'h1);
      check("beq_salto", 32'(obs_salto), 32'h014);
      write_reg(5'd2, 32'd8);
      set_i(6'h04, 5'd1, 5'd2, 16'd4);
      cycle();
      check("beq_nt_pcsrc", 32'(obs_pcsrc), 32'h0);

      // Target wrap in both directions.
      pc = 11'h7FF;
      set_i(6'h04, 5'd1, 5'd1, 16'd2);
      cycle();
      check("wrap_up", 32'(obs_salto), 32'h001);
      pc = 11'h000;
      set_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
      cycle();
      check("wrap_down", 32'(obs_salto), 32'h7FF);

      // bne behind an in-flight load, then resolved.
      write_reg(5'd3, 32'd5);
      set_i(6'h05, 5'd3, 5'd0, 16'd1);
      exmem_mem_read  = 1'b1;
      exmem_write_reg = 5'd3;
      cycle();
      check("bne_haz_stall", 32'(obs_stall), 32'h1);
      check("bne_haz_pcsrc", 32'(obs_pcsrc), 32'h0);
      exmem_mem_read  = 1'b0;
      cycle();
      check("bne_go_pcsrc", 32'(obs_pcsrc), 32'h1);

      // Reset in the middle of a load-use stall.
      write_reg(5'd7, 32'hDEAD_BEEF);
      set_i(6'h23, 5'd1, 5'd2, 16'h0);
      cycle();
      set_r(6'h00, 5'd2, 5'd3, 5'd4);
      #1;
      check("rst_pre_stall", 32'(stall), 32'h1);
      #1 reset = 1'b0;
      #1;
      model_reset();
      check_ex();
      #2 reset = 1'b1;
      set_r(6'h00, 5'd7, 5'd0, 5'd3);
      cycle();
      check("rst_r7", ex_dato1, 32'h0);

      // Randomized traffic with small register indices to provoke hazards and bypasses.
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 8)];
         if (op == 6'h3F) op = 6'($urandom);
         instruccion     = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         pc              = 11'($urandom);
         wb_reg_write    = 1'($urandom);
         wb_write_reg    = 5'($urandom_range(0, 7));
         wb_write_data   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         exmem_mem_read  = ($urandom_range(0, 3) == 0);
         exmem_write_reg = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
Second pipeline stage. It consumes the IF/ID outputs (instruccion, pc = PC+1) and contains the 32x32 register file, the main control decoder, sign extension, early branch resolution and load-use/branch hazard detection. It drives pc_salto/PCSrc back to instruction_fetch and registers everything into the ID/EX pipeline register feeding execute.

Parameters:
ADDR_W, 11, instruction-memory word-address width (pc, pc_salto)
DATA_W, 32, datapath and register width
NREG, 32, register count (5-bit specifiers)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
instruccion  in  32  instruction from IF/ID
pc  in  ADDR_W  PC+1 from IF/ID
wb_reg_write  in  1  write-back enable
wb_write_reg  in  5  write-back destination
wb_write_data  in  32  write-back data
exmem_mem_read  in  1  instruction now in MEM is a load
exmem_write_reg  in  5  destination of that load
pc_salto  out  ADDR_W  branch target, combinational
PCSrc  out  1  branch taken, combinational
stall  out  1  hold PC and IF/ID, combinational
flush_if_id  out  1  squash instruction in IF/ID, combinational
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst  out  1 each  registered control
ex_alu_op  out  2  00 add, 01 sub, 10 R-type funct, 11 logical-immediate
ex_dato1, ex_dato2  out  32 each  registered rs and rt values
ex_inmediato  out  32  registered extended immediate
ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers

Behaviour:
- Reset (async, reset=0): every ex_* output = 0; all 32 registers = 0. Combinational outputs follow from this.
- Decode by opcode [31:26]:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 lw: alu_src, mem_read, mem_to_reg, reg_write.
  - 0x2B sw: alu_src, mem_write.
  - 0x04 beq / 0x05 bne: no ex control.
  - 0x08 addi: alu_src, reg_write, alu_op=00.
  - 0x0C andi / 0x0D ori: alu_src, reg_write, alu_op=11, zero-extend.
  - Anything else decodes as NOP (all control 0).
- Immediate: sign-extend [15:0], except zero-extend for andi/ori.
- Register file:
  - Two combinational reads; write on rising edge when wb_reg_write=1 and wb_write_reg!=0.
  - r0 always reads 0.
  - Same-cycle bypass: a read whose address equals wb_write_reg while wb_reg_write=1 (address !=0) returns wb_write_data.
- Latency: one cycle; ID/EX loads on every rising edge.
- Source use: rt counts as a source for R-type, sw, beq and bne only.
- Load-use hazard: ex_mem_read=1, ex_rt!=0 and ex_rt equals a used source -> stall=1.
- Branch hazard (beq/bne only), stall=1 if either holds:
  - ex_reg_write=1 and the ID/EX destination (ex_reg_dst ? ex_rd : ex_rt), nonzero, equals rs or rt; or
  - exmem_mem_read=1 and exmem_write_reg, nonzero, equals rs or rt.
- While stall=1: the ID/EX register loads a bubble (all control 0; data fields don't-care but deterministic), PCSrc=0 and flush_if_id=0. IF/ID holds, so the same instruction re-decodes next cycle.
- Branch resolution (stall=0):
  - Compare bypassed rs and rt values: beq taken if equal, bne taken if unequal.
  - When taken: PCSrc=1, flush_if_id=1, pc_salto = pc + imm[10:0], modulo 2^ADDR_W (wraps).
  - The branch itself enters ID/EX as a NOP.
- Not taken: PCSrc=0; pc_salto = pc + imm anyway (don't-care).
- Simultaneous events: a WB write and a read of the same register in one cycle returns the new value. Stall has priority over branch.
- Reset mid-stall clears ID/EX immediately; the register file is also cleared.

Decomposition:
- Shared package decode_pkg: opcode constants, alu_op encodings, control bundle struct.
- One sub-module, register_file: 2 read ports, 1 write port, r0 = 0, write-to-read bypass.
- Decoder and hazard logic stay inline.

Test Plan:
- Assert reset (reset=0) mid-stream -> all ex_* = 0 the same cycle; read of r7 after release = 0.
- wb write r5=0x00001234 in the same cycle as decoding add r3,r5,r0 -> next edge ex_dato1=0x00001234, ex_reg_dst=1, ex_alu_op=10.
- lw r2,0(r1) followed by add r4,r2,r3 -> stall=1 for exactly one cycle, bubble (ex_reg_write=0); the add then issues with ex_rs=2.
- r1=r2=7, beq r1,r2,+4 with pc=0x010 -> PCSrc=1, pc_salto=0x014, flush_if_id=1; with r2=8 -> PCSrc=0.
- pc=0x7FF, beq taken with imm=+2 -> pc_salto=0x001 (wrap); imm=0xFFFF with pc=0x000 -> pc_salto=0x7FF.
- bne r3,r0 with exmem_mem_read=1 and exmem_write_reg=3 -> stall=1 and PCSrc=0. The next cycle, with that hazard cleared and r3=5 -> PCSrc=1.
